// File: rtl/multi_cycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_adder
// Description : WIDTH-bit add/subtract computed CHUNK bits per clock, LSB
//               slice first, with carry rippled through a register.
//               start/busy/done handshake; reports cout, ovf and zero.
//               Optional macro SATURATE_EN clamps sum on signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int                c_NSLICE   = WIDTH / CHUNK;
    localparam int                c_IDXW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [c_IDXW-1:0] idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  w_a_sl;
    logic [CHUNK-1:0]  w_b_sl;
    logic [CHUNK:0]    w_sl_sum;
    logic              w_msb_cin;
    logic              w_sl_ovf;
    logic              w_last;

    // Carry into the slice MSB is recovered as a ^ b ^ s at that bit.
    always_comb begin
        w_a_sl    = a_q[idx_q*CHUNK +: CHUNK];
        w_b_sl    = b_q[idx_q*CHUNK +: CHUNK];
        w_sl_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, carry_q};
        w_msb_cin = w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_sl_sum[CHUNK-1];
        w_sl_ovf  = w_msb_cin ^ w_sl_sum[CHUNK];
        w_last    = (idx_q == c_LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = w_sl_sum[CHUNK-1:0];
                carry_d                     = w_sl_sum[CHUNK];
                if (w_last) begin
                    cout_d  = w_sl_sum[CHUNK];
                    ovf_d   = w_sl_ovf;
                    state_d = S_DONE;
`ifdef SATURATE_EN
                    if (w_sl_ovf) begin
                        sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`else
                    // wrapping result: the slice write above is final
`endif
                end else begin
                    idx_d = idx_q + c_IDXW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = ~|sum_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_adder
// Description : Scoreboard bench for multi_cycle_adder (WIDTH=16, CHUNK=4);
//               expected results follow SATURATE_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi,
                                   input logic ci, input logic si);
        logic [15:0] be;
        logic [16:0] f;
        exp_t        e;
        be     = si ? ~bi : bi;
        f      = {1'b0, ai} + {1'b0, be} + {16'd0, (si ? 1'b1 : ci)};
        e.sum  = f[15:0];
        e.cout = f[16];
        e.ovf  = (ai[15] == be[15]) && (f[15] != ai[15]);
`ifdef SATURATE_EN
        if (e.ovf) e.sum = ai[15] ? 16'h8000 : 16'h7FFF;
`endif
        e.zero = (e.sum == 16'h0000);
        return e;
    endfunction

    // Drive at a negedge, accept on the next posedge, then scramble inputs.
    task automatic issue(input logic [15:0] ai, input logic [15:0] bi,
                         input logic ci, input logic si, input bit push);
        a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
        if (push) sb.push_back(model(ai, bi, ci, si));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("done_unexpected", done, 0);
            end else begin
                e = sb.pop_front();
                check("sum",  sum,  e.sum);
                check("cout", cout, e.cout);
                check("ovf",  ovf,  e.ovf);
                check("zero", zero, e.zero);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum",  sum,  0);
        check("rst_cout", cout, 0);
        check("rst_ovf",  ovf,  0);
        check("rst_zero", zero, 1);
        rst = 1'b0;
        @(negedge clk);

        // 0x7FFF + 1: exact latency and busy window
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lat_busy", busy, 1);
            check("lat_early_done", done, 0);
        end
        @(negedge clk);
        check("lat_done", done, 1);
        check("lat_busy_lo", busy, 0);
        @(negedge clk);
        check("done_pulse_len", done, 0);

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1); wait_done();
        issue(16'h000F, 16'h0000, 1'b1, 1'b0, 1); wait_done();
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1); wait_done();
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1); wait_done();
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1); wait_done();
        for (int i = 0; i < 4; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
            wait_done();
        end
        @(negedge clk);

        // start held high: ignored while busy, accepted in the done cycle
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        sb.push_back(model(16'h1234, 16'h1111, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        a = 16'h4321; b = 16'h0F0F; cin = 1'b1; sub = 1'b1;
        sb.push_back(model(16'h4321, 16'h0F0F, 1'b1, 1'b1));
        wait_done();
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_busy", busy, 1);
            check("b2b_early_done", done, 0);
        end
        @(negedge clk);
        check("b2b_done", done, 1);
        @(negedge clk);

        // reset asserted in the second RUN cycle aborts the op
        issue(16'h00F0, 16'h0F00, 1'b0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum",  sum,  0);
        check("abort_zero", zero, 1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        issue(16'h0ABC, 16'h1001, 1'b1, 1'b0, 1); wait_done();
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
